bbox_iterator: RTL

BBOX_ITERATOR -- requirements
Module: bbox_iterator

---
 rtl/bbox_iterator.sv | 102 ++++++++++
 1 files changed

// File: rtl/bbox_iterator.sv
// bbox_iterator: latches a triangle and walks its bounding box in raster order, one sample per cycle.
module bbox_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R14U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R14S [2][2],
    input  logic                     validTri_R14H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R16S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R16U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R16S [2],
    output logic                     validSamp_R16H
);
    typedef enum logic {WAIT, TEST} state_t;
    localparam logic [SIGFIG-1:0] STEP8 = SIGFIG'(1) << RADIX;
    localparam logic [SIGFIG-1:0] STEP4 = SIGFIG'(1) << (RADIX - 1);
    localparam logic [SIGFIG-1:0] STEP2 = SIGFIG'(1) << (RADIX - 2);
    localparam logic [SIGFIG-1:0] STEP1 = SIGFIG'(1) << (RADIX - 3);
    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic signed [SIGFIG-1:0] sample_q [2];
    logic signed [SIGFIG-1:0] sample_d [2];
    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];
    logic signed [SIGFIG-1:0] box_q [2][2];
    logic signed [SIGFIG-1:0] box_d [2][2];
    logic        [SIGFIG-1:0] step_q, step_d, step_sel;
    logic signed [SIGFIG:0]   nx, ny;
    logic                     x_ok, y_ok;
    assign halt_RnnnnL    = (state_q == WAIT) && !rst;
    assign tri_R16S       = tri_q;
    assign color_R16U     = color_q;
    assign sample_R16S    = sample_q;
    assign validSamp_R16H = valid_q;
    assign step_sel = subSample_RnnnnU == 4'b0100 ? STEP4 :
                      subSample_RnnnnU == 4'b0010 ? STEP2 :
                      subSample_RnnnnU == 4'b0001 ? STEP1 : STEP8;
    // One extra bit keeps sums near the positive limit from wrapping negative.
    assign nx   = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    assign ny   = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    assign x_ok = nx <= $signed({box_q[1][0][SIGFIG-1], box_q[1][0]});
    assign y_ok = ny <= $signed({box_q[1][1][SIGFIG-1], box_q[1][1]});
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        sample_d = sample_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        step_d   = step_q;
        if (state_q == WAIT) begin
            valid_d = 1'b0;
            if (validTri_R14H && halt_RnnnnL) begin
                tri_d       = tri_R14S;
                color_d     = color_R14U;
                box_d       = box_R14S;
                step_d      = step_sel;
                sample_d[0] = box_R14S[0][0];
                sample_d[1] = box_R14S[0][1];
                valid_d     = 1'b1;
                state_d     = TEST;
            end
        end else if (x_ok) begin
            sample_d[0] = nx[SIGFIG-1:0];
        end else if (y_ok) begin
            sample_d[0] = box_q[0][0];
            sample_d[1] = ny[SIGFIG-1:0];
        end else begin
            valid_d = 1'b0;
            state_d = WAIT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT;
            valid_q  <= 1'b0;
            sample_q <= '{default: '0};
            tri_q    <= '{default: '0};
            color_q  <= '{default: '0};
            box_q    <= '{default: '0};
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            step_q   <= step_d;
        end
    end
endmodule
